// File: rtl/wb_write_arbiter_pkg.sv
// rtl/wb_write_arbiter_pkg.sv - shared processor constants and register-index helpers
package proc_pkg;

  localparam int REG_W         = 32;
  localparam int NUM_REGS      = 32;
  localparam int REG_IDX_W     = 5;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [REG_IDX_W-1:0] regIdx_t;
  typedef logic [NUM_REGS-1:0]  regMask_t;

  // One-hot mask for a register index; r0 is hardwired so it never shows as busy
  function automatic regMask_t regMask(input regIdx_t idx);
    regMask_t m;
    m = '0;
    if (idx != '0) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - writeback arbiter bus: pipeline/multdiv requests and register-file write port
interface wb_write_arbiter_if #(
  parameter int REG_W = 32,
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             pipe_we;
  logic [4:0]       pipe_rd;
  logic [REG_W-1:0] pipe_data;

  logic             md_valid;
  logic             md_ready;
  logic [4:0]       md_rd;
  logic [REG_W-1:0] md_data;

  logic             ctrl_writeEnable;
  logic [4:0]       ctrl_writeReg;
  logic [REG_W-1:0] data_writeReg;

  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] q_count;

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  busy_vec, q_count
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output busy_vec, q_count
  );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// rtl/wb_write_arbiter_fifo.sv - long-latency result queue with per-entry valid and rd invalidation
module wb_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = 32
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       push,
  input  regIdx_t                    pushRd,
  input  logic [DW-1:0]              pushData,
  input  logic                       pop,
  input  logic                       invEn,
  input  regIdx_t                    invRd,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output regIdx_t                    headRd,
  output logic [DW-1:0]              headData,
  output logic                       headValid,
  output regMask_t                   queuedMask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  regIdx_t          entryRd   [DEPTH];
  logic [DW-1:0]    entryData [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countQ;
  logic             doPush;
  logic             doPop;

  assign full      = (countQ == CNT_W'(DEPTH));
  assign empty     = (countQ == '0);
  assign count     = countQ;
  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign headRd    = entryRd[rdPtr];
  assign headData  = entryData[rdPtr];
  assign headValid = entryValid[rdPtr];

  // Payload storage; contents are only meaningful where the slot is occupied
  always_ff @(posedge clock) begin
    if (doPush) begin
      entryRd[wrPtr]   <= pushRd;
      entryData[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy; pointer width makes the wrap modulo DEPTH implicit
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Per-entry valid: set on push, cleared on pop or when a newer pipeline write hits the same rd
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      entryValid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (doPush && (wrPtr == PTR_W'(i))) begin
          entryValid[i] <= 1'b1;
        end else if (doPop && (rdPtr == PTR_W'(i))) begin
          entryValid[i] <= 1'b0;
        end else if (invEn && (entryRd[i] == invRd)) begin
          entryValid[i] <= 1'b0;
        end
      end
    end
  end

  // Registers with a still-live queued write
  always_comb begin
    queuedMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) queuedMask = queuedMask | regMask(entryRd[i]);
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and multdiv writebacks into one registered register-file write
module wb_write_arbiter
  import proc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int REG_W = proc_pkg::REG_W
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  wb_write_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             qFull;
  logic             qEmpty;
  logic [CNT_W-1:0] qCount;
  regIdx_t          headRd;
  logic [REG_W-1:0] headData;
  logic             headValid;
  regMask_t         queuedMask;

  logic             mdFire;
  logic             mdPush;
  logic             qPop;
  logic             invEn;

  logic             writeEnable;
  regIdx_t          writeReg;
  logic [REG_W-1:0] writeData;

  // Accept/discard decisions for the multdiv result and the pop/invalidate for this cycle
  always_comb begin
    mdFire = bus.md_valid && !qFull;
    // rd=0 results and results already superseded by this cycle's pipeline write are dropped
    mdPush = mdFire && (bus.md_rd != '0) &&
             !(bus.pipe_we && (bus.pipe_rd == bus.md_rd));
    qPop   = !bus.pipe_we && !qEmpty;
    invEn  = bus.pipe_we && (bus.pipe_rd != '0);
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (REG_W)
  ) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (mdPush),
    .pushRd     (bus.md_rd),
    .pushData   (bus.md_data),
    .pop        (qPop),
    .invEn      (invEn),
    .invRd      (bus.pipe_rd),
    .full       (qFull),
    .empty      (qEmpty),
    .count      (qCount),
    .headRd     (headRd),
    .headData   (headData),
    .headValid  (headValid),
    .queuedMask (queuedMask)
  );

  // Output stage: pipeline has priority, then the queue head, otherwise idle
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
    end else if (bus.pipe_we) begin
      writeEnable <= (bus.pipe_rd != '0);
      writeReg    <= bus.pipe_rd;
      writeData   <= bus.pipe_data;
    end else if (qPop) begin
      writeEnable <= headValid && (headRd != '0);
      writeReg    <= headRd;
      writeData   <= headData;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  assign bus.md_ready         = !qFull;
  assign bus.q_count          = qCount;
  assign bus.ctrl_writeEnable = writeEnable;
  assign bus.ctrl_writeReg    = writeReg;
  assign bus.data_writeReg    = writeData;
  assign bus.busy_vec         = queuedMask | (writeEnable ? regMask(writeReg) : '0);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - directed self-checking bench for wb_write_arbiter
module tb_wb_write_arbiter;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clock = ~clock;

  wb_write_arbiter_if #(.REG_W(32), .DEPTH(4)) bus ();

  wb_write_arbiter #(.DEPTH(4), .REG_W(32)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    bus.pipe_we   = 1'b0;
    bus.pipe_rd   = '0;
    bus.pipe_data = '0;
    bus.md_valid  = 1'b0;
    bus.md_rd     = '0;
    bus.md_data   = '0;
  endtask

  initial begin
    idleInputs();

    // reset state
    repeat (2) @(negedge clock);
    check("rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
    check("rst_reg",   32'(bus.ctrl_writeReg),    32'd0);
    check("rst_data",  bus.data_writeReg,         32'd0);
    check("rst_busy",  bus.busy_vec,              32'd0);
    check("rst_count", 32'(bus.q_count),          32'd0);
    ctrl_reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(bus.md_ready), 32'd1);

    // single pipeline write
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    @(negedge clock);
    idleInputs();
    check("pipe_we",   32'(bus.ctrl_writeEnable), 32'd1);
    check("pipe_reg",  32'(bus.ctrl_writeReg),    32'd5);
    check("pipe_data", bus.data_writeReg,         32'hDEADBEEF);
    check("pipe_busy", bus.busy_vec,              32'h0000_0020);
    @(negedge clock);
    check("pipe_idle", 32'(bus.ctrl_writeEnable), 32'd0);

    // fill the queue while the pipeline holds priority, then drain in order
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_data = 32'h99;
    for (int i = 1; i <= 4; i++) begin
      bus.md_valid = 1'b1; bus.md_rd = 5'(i); bus.md_data = 32'(i * 32'h11);
      @(negedge clock);
    end
    bus.md_valid = 1'b0;
    check("full_count", 32'(bus.q_count),  32'd4);
    check("full_ready", 32'(bus.md_ready), 32'd0);
    check("full_busy",  bus.busy_vec,      32'h0000_021E);
    bus.pipe_we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check($sformatf("drain%0d_we", i),   32'(bus.ctrl_writeEnable), 32'd1);
      check($sformatf("drain%0d_reg", i),  32'(bus.ctrl_writeReg),    32'(i));
      check($sformatf("drain%0d_data", i), bus.data_writeReg,         32'(i * 32'h11));
    end
    @(negedge clock);
    check("drain_idle",  32'(bus.ctrl_writeEnable), 32'd0);
    check("drain_count", 32'(bus.q_count),          32'd0);

    // pipeline write supersedes a pending queued rd=7
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd10; bus.pipe_data = 32'h1;
    bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h77;
    @(negedge clock);
    bus.md_valid = 1'b0;
    check("inv_pending", 32'(bus.busy_vec[7]), 32'd1);
    check("inv_count0",  32'(bus.q_count),     32'd1);
    bus.pipe_rd = 5'd7; bus.pipe_data = 32'hAA;
    @(negedge clock);
    bus.pipe_we = 1'b0;
    check("inv_we",     32'(bus.ctrl_writeEnable), 32'd1);
    check("inv_reg",    32'(bus.ctrl_writeReg),    32'd7);
    check("inv_data",   bus.data_writeReg,         32'hAA);
    check("inv_count1", 32'(bus.q_count),          32'd1);
    @(negedge clock);
    check("inv_pop_we", 32'(bus.ctrl_writeEnable), 32'd0);
    check("inv_count2", 32'(bus.q_count),          32'd0);
    check("inv_busy",   bus.busy_vec,              32'd0);

    // md result to r0 completes but is dropped
    idleInputs();
    bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_data = 32'h55;
    check("r0_ready", 32'(bus.md_ready), 32'd1);
    @(negedge clock);
    bus.md_valid = 1'b0;
    check("r0_count", 32'(bus.q_count),          32'd0);
    check("r0_we0",   32'(bus.ctrl_writeEnable), 32'd0);
    @(negedge clock);
    check("r0_we1",   32'(bus.ctrl_writeEnable), 32'd0);

    // same-cycle md and pipeline write to r3: pipeline wins, md dropped
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h33AA;
    bus.md_valid = 1'b1; bus.md_rd = 5'd3; bus.md_data = 32'h3B;
    @(negedge clock);
    idleInputs();
    check("same_we",    32'(bus.ctrl_writeEnable), 32'd1);
    check("same_reg",   32'(bus.ctrl_writeReg),    32'd3);
    check("same_data",  bus.data_writeReg,         32'h33AA);
    check("same_count", 32'(bus.q_count),          32'd0);
    @(negedge clock);
    check("same_idle",  32'(bus.ctrl_writeEnable), 32'd0);

    // reset with three queued entries
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd12; bus.pipe_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      bus.md_valid = 1'b1; bus.md_rd = 5'(20 + i); bus.md_data = 32'(i + 1);
      @(negedge clock);
    end
    check("mid_count", 32'(bus.q_count), 32'd3);
    #2;
    ctrl_reset = 1'b1;
    idleInputs();
    #1;
    check("mid_we",    32'(bus.ctrl_writeEnable), 32'd0);
    check("mid_reg",   32'(bus.ctrl_writeReg),    32'd0);
    check("mid_data",  bus.data_writeReg,         32'd0);
    check("mid_busy",  bus.busy_vec,              32'd0);
    check("mid_count0", 32'(bus.q_count),         32'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("post%0d_we", i),    32'(bus.ctrl_writeEnable), 32'd0);
      check($sformatf("post%0d_ready", i), 32'(bus.md_ready),         32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: number of entries in the long-latency result queue; power of two, 2..8.
REQ-002 Parameter REG_W, default 32: data width of one register.
REQ-003 Clock and reset: one clock, clock; reset is asynchronous and active-high, ctrl_reset.
REQ-004 clock  in  1  clock; all state updates on its rising edge.
REQ-005 ctrl_reset  in  1  asynchronous active-high reset.
REQ-006 pipe_we  in  1  pipeline writeback request this cycle; never stalled.
REQ-007 pipe_rd  in  5  pipeline destination register.
REQ-008 pipe_data  in  REG_W  pipeline result.
REQ-009 md_valid  in  1  multdiv result valid.
REQ-010 md_ready  out  1  queue can accept a multdiv result; high iff queue is not full.
REQ-011 md_rd  in  5  multdiv destination register.
REQ-012 md_data  in  REG_W  multdiv result.
REQ-013 ctrl_writeEnable  out  1  registered write strobe to the register file.
REQ-014 ctrl_writeReg  out  5  registered write index.
REQ-015 data_writeReg  out  REG_W  registered write data.
REQ-016 busy_vec  out  32  bit r high while any queued or output-stage write targets r; bit 0 always 0.
REQ-017 q_count  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-018 md result accepted when md_valid && md_ready on a rising edge; entries are pushed in FIFO order.
REQ-019 Each cycle the output stage loads exactly one selection: pipe_we=1 selects the pipeline write; otherwise a non-empty queue pops its head; otherwise ctrl_writeEnable loads 0.
REQ-020 Latency: the selected write appears on ctrl_write* exactly one cycle after selection; the register file commits it on the following edge.
REQ-021 Any write with rd=0 (pipeline or queue) produces ctrl_writeEnable=0 and is not enqueued; a handshake with md_rd=0 still completes.
REQ-022 Pipeline write to rd=r invalidates every valid queue entry with rd=r in the same edge; invalidated entries still pop in order but produce ctrl_writeEnable=0.
REQ-023 md_valid && md_ready with md_rd equal to pipe_rd while pipe_we=1 in the same cycle: the handshake completes and the md result is discarded.
REQ-024 Full queue: md_ready=0 and nothing is pushed; pop and push in the same cycle on a full queue is not permitted (md_ready is computed from the current count, not the next count).
REQ-025 Empty queue with pipe_we=0: no pop occurs, count stays 0, and the output stage is idle.
REQ-026 Queue pointers wrap modulo DEPTH; q_count equals pushes minus pops, bounded 0..DEPTH.
REQ-027 busy_vec is combinational from the valid queue entries and the output stage; it updates the cycle after the state changes.

Reset
REQ-028 ctrl_reset=1 asynchronously clears all queue valid bits, pointers and q_count, and sets ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0 and busy_vec=0.
REQ-029 Reset asserted mid-operation drops all queued results without emitting them; md_ready=1 from the first edge after deassertion.

Structure
REQ-030 Constants REG_W, NUM_REGS=32, REG_IDX_W=5 and the default DEPTH belong in a shared package (proc_pkg).
REQ-031 The queue is one sub-module, wb_fifo (storage, pointers, count, per-entry valid and rd match/invalidate); arbitration and the output register stay in wb_write_arbiter.

Verification
REQ-032 Reset, then pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF -> one cycle later ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF.
REQ-033 Push 4 md results (rd 1..4, data 0x11..0x44) with pipe_we held 1 (rd=9) -> md_ready=0 after the 4th push and q_count=4; release pipe_we -> writes to rd 1,2,3,4 drain in order on consecutive cycles.
REQ-034 Queue entry rd=7 is pending, then a pipeline write to rd=7 with 0xAA -> only the pipeline write to r7 appears; the queue slot later pops with ctrl_writeEnable=0; busy_vec[7] is cleared afterwards.
REQ-035 md_valid with md_rd=0 and data 0x55 -> handshake completes, q_count stays 0, and no write is emitted.
REQ-036 md_valid with rd=3 in the same cycle as pipe_we with rd=3 -> only the pipeline value reaches r3 and q_count is unchanged.
REQ-037 Assert ctrl_reset with 3 entries queued -> all outputs 0 and q_count=0 immediately; no queued write is emitted after deassertion.
